// File: rtl/microcode_sequencer.sv
// Microcode sequencer: a PC walks a programmable instruction store and decodes
// the A..F/T control fields for the data bank and arithmetic unit. Flow control
// covers INC/WAIT/HALT, jumps, a single-level hardware loop counter and a
// CALL/RET stack with sticky overflow/underflow reporting.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | ready=1, pc holds, waiting for start; ctl_e/ctl_f forced low
// S_RUN  | executing one instruction per cycle (WAIT may stall)
module microcode_sequencer #(
  parameter int PC_W  = 8,
  parameter int AW    = 5,
  parameter int CNT_W = 8,
  parameter int STK_D = 4,
  localparam int IW   = 2*AW + 7 + PC_W,
  localparam int SP_W = $clog2(STK_D + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [PC_W-1:0] start_addr,
  input  logic            abort,
  input  logic            continue_i,
  input  logic            rom_we,
  input  logic [PC_W-1:0] rom_waddr,
  input  logic [IW-1:0]   rom_wdata,
  output logic [AW-1:0]   ctl_a,
  output logic [AW-1:0]   ctl_b,
  output logic [2:0]      ctl_c,
  output logic [1:0]      ctl_d,
  output logic            ctl_e,
  output logic            ctl_f,
  output logic [PC_W-1:0] ctl_t,
  output logic            ready,
  output logic [1:0]      err,
  output logic [PC_W-1:0] pc_dbg,
  output logic [SP_W-1:0] sp_dbg
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam logic [2:0] OP_INC  = 3'b000;
  localparam logic [2:0] OP_WAIT = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b010;
  localparam logic [2:0] OP_JMP  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;
  localparam logic [2:0] OP_LDC  = 3'b110;
  localparam logic [2:0] OP_LOOP = 3'b111;

  localparam logic [SP_W-1:0] STK_MAX = SP_W'(STK_D);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        err_q, err_d;
  logic              push_en;
  logic [PC_W-1:0]   pc_inc;
  logic [IW-1:0]     instr;

  // Stack is sized to the full sp index range so sp can index it directly;
  // entries at or above STK_D are never written.
  logic [IW-1:0]     mem_q [0:(1<<PC_W)-1];
  logic [PC_W-1:0]   stk_q [0:(1<<SP_W)-1];

  assign instr  = mem_q[pc_q];
  assign pc_inc = pc_q + PC_W'(1);
  assign ready  = (state_q == S_IDLE);

  assign ctl_a  = instr[IW-1 -: AW];
  assign ctl_b  = instr[IW-AW-1 -: AW];
  assign ctl_c  = instr[IW-2*AW-1 -: 3];
  assign ctl_d  = instr[IW-2*AW-4 -: 2];
  assign ctl_e  = instr[PC_W+1] & ~ready;
  assign ctl_f  = instr[PC_W] & ~ready;
  assign ctl_t  = instr[PC_W-1:0];

  assign err    = err_q;
  assign pc_dbg = pc_q;
  assign sp_dbg = sp_q;

  // Instruction store: synchronous write, never reset, writable while running.
  always_ff @(posedge clk) begin
    if (rom_we) mem_q[rom_waddr] <= rom_wdata;
  end

  // Return-address stack write on CALL.
  always_ff @(posedge clk) begin
    if (push_en) stk_q[sp_q] <= pc_inc;
  end

  // Sequencer state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      sp_q    <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state decode: abort first, then start when idle, else the flow opcode.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    push_en = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      sp_d    = '0;
      cnt_d   = '0;
    end else if (state_q == S_IDLE) begin
      if (start) begin
        state_d = S_RUN;
        pc_d    = start_addr;
        sp_d    = '0;
        cnt_d   = '0;
        err_d   = '0;
      end
    end else begin
      case (ctl_c)
        OP_INC:  pc_d = pc_inc;
        OP_WAIT: if (continue_i) pc_d = pc_inc;
        OP_HALT: state_d = S_IDLE;
        OP_JMP:  pc_d = ctl_t;
        OP_CALL: begin
          if (sp_q < STK_MAX) begin
            push_en = 1'b1;
            sp_d    = sp_q + SP_W'(1);
            pc_d    = ctl_t;
          end else begin
            err_d[0] = 1'b1;
            state_d  = S_IDLE;
          end
        end
        OP_RET: begin
          if (sp_q != '0) begin
            sp_d = sp_q - SP_W'(1);
            pc_d = stk_q[sp_q - SP_W'(1)];
          end else begin
            err_d[1] = 1'b1;
            state_d  = S_IDLE;
          end
        end
        OP_LDC: begin
          cnt_d = ctl_t[CNT_W-1:0];
          pc_d  = pc_inc;
        end
        OP_LOOP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            pc_d  = ctl_t;
          end else begin
            pc_d = pc_inc;
          end
        end
        default: pc_d = pc_inc;
      endcase
    end
  end

endmodule
